// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//   Multi-channel input conditioner for push-buttons and switches.
//   Each channel is an independent debounce_lane instance. A lane contains:
//     - a 2-flop synchroniser
//     - a saturating stability counter
//     - the debounced level
//     - one-cycle rise/fall strobes
//     - an optional auto-repeat strobe generator
//   The bank adds one shared output: a registered "changed" flag, the OR of
//   every rise and fall strobe, asserted in the same cycle as those strobes.
//
// Parameters
//   CHANNELS      number of independent input channels (>= 1)
//   COUNTER_BITS  stability counter width; an input must stay stable for
//                 2^COUNTER_BITS cycles before the output follows it
//   REPEAT_BITS   auto-repeat counter width
//   REPEAT_DELAY  cycles from a debounced rise to the first repeat strobe
//                 (1 <= REPEAT_DELAY < 2^REPEAT_BITS)
//   REPEAT_PERIOD cycles between later repeat strobes
//                 (1 <= REPEAT_PERIOD <= REPEAT_DELAY)
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in         raw asynchronous inputs, one bit per channel
//   repeat_en  enables auto-repeat on all channels; sampled every cycle
//   out        debounced level per channel
//   rise       one-cycle strobe when out[i] goes 0->1
//   fall       one-cycle strobe when out[i] goes 1->0
//   rpt        one-cycle auto-repeat strobe per channel
//   changed    OR of all rise/fall bits, aligned with those strobes
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// debounce_lane
//   Conditioning logic for a single channel.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   in_i         raw asynchronous input bit
//   repeat_en_i  auto-repeat enable
//   out_o        debounced level
//   rise_o       registered rise strobe
//   fall_o       registered fall strobe
//   rpt_o        registered repeat strobe
//   chg_d_o      next-state value of (rise | fall); the bank ORs these across
//                all lanes into its single registered "changed" flag
// ---------------------------------------------------------------------------
module debounce_lane #(
  parameter int COUNTER_BITS  = 4,
  parameter int REPEAT_BITS   = 8,
  parameter int REPEAT_DELAY  = 200,
  parameter int REPEAT_PERIOD = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  input  logic repeat_en_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic rpt_o,
  output logic chg_d_o
);

  // Value rpt_cnt holds on the edge that fires a repeat strobe.
  localparam logic [REPEAT_BITS-1:0] RPT_LAST = REPEAT_BITS'(REPEAT_DELAY - 1);

  // Reload value after a strobe. Counting up from here reaches RPT_LAST
  // again after exactly REPEAT_PERIOD edges.
  localparam logic [REPEAT_BITS-1:0] RPT_RELOAD =
    REPEAT_BITS'(REPEAT_DELAY - REPEAT_PERIOD);

  logic                    sync1_q, sync2_q;
  logic                    prev_q, prev_d;
  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic                    out_q, out_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic [REPEAT_BITS-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic                    rpt_q, rpt_d;

  always_comb begin
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    rpt_cnt_d = rpt_cnt_q + REPEAT_BITS'(1);
    rpt_d     = 1'b0;

    // Stability qualification.
    // Any change on the synchronised input restarts the count.
    // The output only follows once the counter has saturated.
    // The counter then holds at all-ones: it never wraps.
    if (sync2_q != prev_q) begin
      prev_d = sync2_q;
      cnt_d  = '0;
    end else if (&cnt_q) begin
      out_d = prev_q;
    end else begin
      cnt_d = cnt_q + COUNTER_BITS'(1);
    end

    // Strobes fire only on an actual level change. Saturating when prev
    // already equals out issues no strobe.
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;

    // Auto-repeat.
    // The decision keys off out_d rather than out_q. On the edge where the
    // output falls, the counter is therefore already cleared, so a repeat
    // strobe can never share a cycle with fall. Clearing on rise_d likewise
    // keeps repeat strobes out of the rise cycle.
    if (!out_d || !repeat_en_i || rise_d) begin
      rpt_cnt_d = '0;
    end else if (rpt_cnt_q == RPT_LAST) begin
      rpt_d     = 1'b1;
      rpt_cnt_d = RPT_RELOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      rpt_cnt_q <= '0;
      rpt_q     <= 1'b0;
    end else begin
      sync1_q   <= in_i;
      sync2_q   <= sync1_q;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      rpt_cnt_q <= rpt_cnt_d;
      rpt_q     <= rpt_d;
    end
  end

  assign out_o   = out_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign rpt_o   = rpt_q;
  assign chg_d_o = rise_d | fall_d;

endmodule

module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int COUNTER_BITS  = 4,
  parameter int REPEAT_BITS   = 8,
  parameter int REPEAT_DELAY  = 200,
  parameter int REPEAT_PERIOD = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  input  logic                repeat_en,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rpt,
  output logic                changed
);

  logic [CHANNELS-1:0] chg_d;
  logic                changed_q, changed_d;

  // One independent lane per channel; no counter is shared between lanes.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    debounce_lane #(
      .COUNTER_BITS (COUNTER_BITS),
      .REPEAT_BITS  (REPEAT_BITS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_i       (in[g]),
      .repeat_en_i(repeat_en),
      .out_o      (out[g]),
      .rise_o     (rise[g]),
      .fall_o     (fall[g]),
      .rpt_o      (rpt[g]),
      .chg_d_o    (chg_d[g])
    );
  end

  // changed is built from the lanes' next-state strobes. It is registered
  // on the same edge as the strobes themselves, so it lines up with them
  // exactly.
  assign changed_d = |chg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed_q <= 1'b0;
    else        changed_q <= changed_d;
  end

  assign changed = changed_q;

endmodule
